// File: rtl/data_ram_pkg.sv
// ============================================================================
// Module : data_ram_pkg
// Purpose: Shared types and helpers for the handshaked data RAM
//          (data_ram_hs) and its storage array (data_ram_array).
//          Contents:
//            - state_t           : FSM state encoding (IDLE=0, WAIT=1, RESP=2)
//            - MAX_WAIT_CYCLES   : upper bound for the WAIT_CYCLES parameter
//            - WAIT_CNT_W        : wait-counter width
//            - be_w()/ofs_w()    : byte-lane count and byte-offset width
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package data_ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int MAX_WAIT_CYCLES = 15;
  localparam int WAIT_CNT_W      = 4;

  // Number of byte lanes in a data word.
  function automatic int be_w(input int data_w);
    return data_w / 8;
  endfunction

  // log2 of the lane count, i.e. number of byte-offset address bits.
  function automatic int ofs_w(input int be);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < be) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_ram_array.sv
// ============================================================================
// Module : data_ram_array
// Purpose: Plain word storage with per-byte-lane write enables and a
//          registered read port. The read register only updates when i_re
//          is high, so its output stays stable for the whole response.
// Optional: DATA_RAM_HS_PARITY_EN adds one even-parity bit per byte lane,
//          the i_par_inject input and the o_par_err output.
// Ports:
//   clk        in   clock, rising edge
//   i_we_lane  in   BE_W   per-lane write enable (already gated by caller)
//   i_re       in   1      capture mem[i_idx] into the read register
//   i_idx      in   MEM_AW word index (caller guarantees < DEPTH when used)
//   i_wdata    in   DATA_W write data
//   i_par_inject in 1      (parity build) invert stored parity of written lanes
//   o_par_err  out  1      (parity build) parity mismatch on registered word
//   o_rdata    out  DATA_W registered read data
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module data_ram_array
  import data_ram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int MEM_AW = 10
) (
  input  logic                clk,
  input  logic [DATA_W/8-1:0] i_we_lane,
  input  logic                i_re,
  input  logic [MEM_AW-1:0]   i_idx,
  input  logic [DATA_W-1:0]   i_wdata,
`ifdef DATA_RAM_HS_PARITY_EN
  input  logic                i_par_inject,
  output logic                o_par_err,
`endif
  output logic [DATA_W-1:0]   o_rdata
);

  localparam int c_BE_W = be_w(DATA_W);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    for (int b = 0; b < c_BE_W; b++) begin
      if (i_we_lane[b]) r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
    end
    if (i_re) r_rdata <= r_mem[i_idx];
  end

  assign o_rdata = r_rdata;

`ifdef DATA_RAM_HS_PARITY_EN
  logic [c_BE_W-1:0] r_par [DEPTH];
  logic [c_BE_W-1:0] r_rpar;
  logic [c_BE_W-1:0] w_calc_par;

  // Even parity: stored bit equals the XOR of the lane, so lane+bit has an
  // even number of ones. Injection flips it to model a corrupted cell.
  always_ff @(posedge clk) begin
    for (int b = 0; b < c_BE_W; b++) begin
      if (i_we_lane[b]) r_par[i_idx][b] <= (^i_wdata[b*8 +: 8]) ^ i_par_inject;
    end
    if (i_re) r_rpar <= r_par[i_idx];
  end

  always_comb begin
    w_calc_par = '0;
    for (int b = 0; b < c_BE_W; b++) begin
      w_calc_par[b] = ^r_rdata[b*8 +: 8];
    end
  end

  assign o_par_err = |(w_calc_par ^ r_rpar);
`endif

endmodule

`default_nettype wire

// File: rtl/data_ram_hs.sv
// ============================================================================
// Module : data_ram_hs
// Purpose: Single-port data memory for the load/store path with a
//          valid/ready request and response handshake, byte write strobes,
//          registered read data, programmable wait states and error
//          reporting for misaligned or out-of-range addresses. One
//          transaction is outstanding at a time.
// Optional: DATA_RAM_HS_PARITY_EN adds per-byte parity and the par_inject
//          input; a read with a parity mismatch reports rsp_err.
// Ports:
//   clk        in   clock, rising edge
//   rstn       in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  block can accept a request (IDLE)
//   req_we     in   1 = write, 0 = read
//   req_addr   in   ADDR_W byte address
//   req_wdata  in   DATA_W write data
//   req_be     in   BE_W byte write strobes (ignored on reads)
//   par_inject in   (parity build) invert parity of written lanes
//   rsp_valid  out  response present (RESP)
//   rsp_ready  in   consumer accepts the response
//   rsp_rdata  out  DATA_W read data; 0 for writes and errors
//   rsp_err    out  access error
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module data_ram_hs
  import data_ram_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
`ifdef DATA_RAM_HS_PARITY_EN
  input  logic                par_inject,
`endif
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int c_OFS_W  = ofs_w(be_w(DATA_W));
  localparam int c_IDX_W  = ADDR_W - c_OFS_W;
  localparam int c_MEM_AW = $clog2(DEPTH);
  localparam logic [c_IDX_W:0] c_DEPTH = (c_IDX_W + 1)'(DEPTH);
  localparam logic [WAIT_CNT_W-1:0] c_WAIT_LOAD =
      (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [WAIT_CNT_W-1:0]   r_wcnt;
  logic                    r_addr_err;
  logic                    r_rd_ok;

  logic                    w_acc;
  logic                    w_misaligned;
  logic                    w_oor;
  logic                    w_err;
  logic [c_IDX_W-1:0]      w_idx;
  logic [DATA_W/8-1:0]     w_we_lane;
  logic                    w_re;
  logic [DATA_W-1:0]       w_arr_rdata;

  // --------------------------------------------------------------------------
  // Address decode and checks (evaluated on the live request, used only at
  // the acceptance edge).
  // --------------------------------------------------------------------------
  if (c_OFS_W > 0) begin : g_ofs
    assign w_misaligned = |req_addr[c_OFS_W-1:0];
  end else begin : g_no_ofs
    assign w_misaligned = 1'b0;
  end

  assign w_idx = req_addr[ADDR_W-1:c_OFS_W];
  // Full-width compare so that indices beyond DEPTH never alias into the
  // array through truncation of the upper address bits.
  assign w_oor = ({1'b0, w_idx} >= c_DEPTH);
  assign w_err = w_misaligned | w_oor;

  assign w_acc     = req_valid & req_ready;
  assign w_we_lane = (w_acc & req_we & ~w_err) ? req_be : '0;
  assign w_re      = w_acc & ~req_we & ~w_err;

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
`ifdef DATA_RAM_HS_PARITY_EN
  logic w_par_err;
`endif

  data_ram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .MEM_AW (c_MEM_AW)
  ) u_array (
    .clk          (clk),
    .i_we_lane    (w_we_lane),
    .i_re         (w_re),
    .i_idx        (w_idx[c_MEM_AW-1:0]),
    .i_wdata      (req_wdata),
`ifdef DATA_RAM_HS_PARITY_EN
    .i_par_inject (par_inject),
    .o_par_err    (w_par_err),
`endif
    .o_rdata      (w_arr_rdata)
  );

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
      end
      ST_WAIT: begin
        if (r_wcnt == '0) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Wait counter and response register. Read data itself lives in the
  // array's read register; r_rd_ok selects it only for a good read.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wcnt     <= '0;
      r_addr_err <= 1'b0;
      r_rd_ok    <= 1'b0;
    end else begin
      if (w_acc) begin
        r_wcnt     <= c_WAIT_LOAD;
        r_addr_err <= w_err;
        r_rd_ok    <= ~req_we & ~w_err;
      end else if ((r_state == ST_WAIT) && (r_wcnt != '0)) begin
        r_wcnt <= r_wcnt - 1'b1;
      end
      if (rsp_valid && rsp_ready) begin
        r_addr_err <= 1'b0;
        r_rd_ok    <= 1'b0;
      end
    end
  end

  assign rsp_rdata = r_rd_ok ? w_arr_rdata : '0;

`ifdef DATA_RAM_HS_PARITY_EN
  assign rsp_err = r_addr_err | (r_rd_ok & w_par_err);
`else
  assign rsp_err = r_addr_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_data_ram_hs.sv
// ============================================================================
// Module : tb_data_ram_hs
// Purpose: Self-checking bench for data_ram_hs. Instance 0 uses
//          WAIT_CYCLES=0, instance 1 uses WAIT_CYCLES=3. Expected responses
//          are pushed to a queue at acceptance and popped when the DUT
//          responds. With DATA_RAM_HS_PARITY_EN the parity inject path is
//          also exercised.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_ram_hs;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
`ifdef DATA_RAM_HS_PARITY_EN
  logic        par_inject [2];
`endif

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  data_ram_hs #(.DATA_W(32), .DEPTH(1024), .ADDR_W(32), .WAIT_CYCLES(0)) u_dut0 (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid[0]),
    .req_ready (req_ready[0]),
    .req_we    (req_we[0]),
    .req_addr  (req_addr[0]),
    .req_wdata (req_wdata[0]),
    .req_be    (req_be[0]),
`ifdef DATA_RAM_HS_PARITY_EN
    .par_inject(par_inject[0]),
`endif
    .rsp_valid (rsp_valid[0]),
    .rsp_ready (rsp_ready[0]),
    .rsp_rdata (rsp_rdata[0]),
    .rsp_err   (rsp_err[0])
  );

  data_ram_hs #(.DATA_W(32), .DEPTH(1024), .ADDR_W(32), .WAIT_CYCLES(3)) u_dut3 (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid[1]),
    .req_ready (req_ready[1]),
    .req_we    (req_we[1]),
    .req_addr  (req_addr[1]),
    .req_wdata (req_wdata[1]),
    .req_be    (req_be[1]),
`ifdef DATA_RAM_HS_PARITY_EN
    .par_inject(par_inject[1]),
`endif
    .rsp_valid (rsp_valid[1]),
    .rsp_ready (rsp_ready[1]),
    .rsp_rdata (rsp_rdata[1]),
    .rsp_err   (rsp_err[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", nm, act, req, $time);
    end
  endtask

  // Drive request at a negedge; it is accepted at the following posedge.
  task automatic drive(input int s, input vec_t v, input logic inj);
    int n;
    @(negedge clk);
    req_valid[s] = 1'b1;
    req_we[s]    = v.we;
    req_addr[s]  = v.addr;
    req_wdata[s] = v.wdata;
    req_be[s]    = v.be;
`ifdef DATA_RAM_HS_PARITY_EN
    par_inject[s] = inj;
`else
    if (inj) $display("note: inject ignored without parity build");
`endif
    n = 0;
    while (!req_ready[s] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("req_ready_before_acc[%0d]", s), 32'(req_ready[s]), 32'd1);
  endtask

  // After acceptance: drop valid and scramble request inputs.
  task automatic release_req(input int s);
    #1;
    req_valid[s] = 1'b0;
    req_we[s]    = 1'($urandom);
    req_addr[s]  = $urandom;
    req_wdata[s] = $urandom;
    req_be[s]    = 4'($urandom);
`ifdef DATA_RAM_HS_PARITY_EN
    par_inject[s] = 1'($urandom);
`endif
  endtask

  // Full transaction with rsp_ready held high.
  task automatic txn(input int s, input vec_t v, input int exp_lat, input logic inj, input string tag);
    int   n;
    exp_t e;
    exp_t g;
    drive(s, v, inj);
    @(posedge clk);
    e.rdata = v.rdata;
    e.err   = v.err;
    q.push_back(e);
    release_req(s);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!rsp_valid[s]) chk({tag, "_req_ready_busy"}, 32'(req_ready[s]), 32'd0);
    end while (!rsp_valid[s] && n < 40);
    chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    g = q.pop_front();
    chk({tag, "_rdata"}, rsp_rdata[s], g.rdata);
    chk({tag, "_err"}, 32'(rsp_err[s]), 32'(g.err));
    @(negedge clk);
    chk({tag, "_rsp_done"}, 32'(rsp_valid[s]), 32'd0);
  endtask

  vec_t vt [21];
  vec_t v;

  initial begin
    int   n;
    exp_t g;

    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0;
      req_we[s]    = 1'b0;
      req_addr[s]  = '0;
      req_wdata[s] = '0;
      req_be[s]    = '0;
      rsp_ready[s] = 1'b1;
`ifdef DATA_RAM_HS_PARITY_EN
      par_inject[s] = 1'b0;
`endif
    end

    //          we    addr          wdata          be     rdata          err
    vt[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
    vt[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    vt[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0,         1'b0};
    vt[3]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'h0,         1'b0};
    vt[4]  = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0};
    vt[5]  = '{1'b0, 32'h0000_0022, 32'h0,         4'h0, 32'h0,         1'b1};
    vt[6]  = '{1'b1, 32'h0000_0000, 32'h0102_0304, 4'hF, 32'h0,         1'b0};
    vt[7]  = '{1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b0};
    vt[8]  = '{1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1};
    vt[9]  = '{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0};
    vt[10] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h0102_0304, 1'b0};
    vt[11] = '{1'b1, 32'h0000_0022, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1};
    vt[12] = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0};
    vt[13] = '{1'b1, 32'h0000_0010, 32'h1234_5678, 4'h0, 32'h0,         1'b0};
    vt[14] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    vt[15] = '{1'b1, 32'h0000_0010, 32'h0000_0000, 4'h8, 32'h0,         1'b0};
    vt[16] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'h00AD_BEEF, 1'b0};
    vt[17] = '{1'b0, 32'h0000_1004, 32'h0,         4'h0, 32'h0,         1'b1};
    vt[18] = '{1'b0, 32'hFFFF_FFF0, 32'h0,         4'h0, 32'h0,         1'b1};
    vt[19] = '{1'b0, 32'h0000_0021, 32'h0,         4'h0, 32'h0,         1'b1};
    vt[20] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h0102_0304, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rst_rsp_valid[%0d]", s), 32'(rsp_valid[s]), 32'd0);
      chk($sformatf("rst_rsp_rdata[%0d]", s), rsp_rdata[s], 32'd0);
      chk($sformatf("rst_rsp_err[%0d]", s), 32'(rsp_err[s]), 32'd0);
    end
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_req_ready0", 32'(req_ready[0]), 32'd1);
    chk("rst_req_ready3", 32'(req_ready[1]), 32'd1);

    // Table-driven vectors on the zero-wait instance
    for (int i = 0; i < 21; i++) begin
      txn(0, vt[i], 1, 1'b0, $sformatf("v%0d", i));
    end

    // WAIT_CYCLES=3: write, then read with rsp_ready held low
    v = '{1'b1, 32'h0000_0040, 32'hA5A5_5A5A, 4'hF, 32'h0, 1'b0};
    txn(1, v, 4, 1'b0, "w3_wr");
    rsp_ready[1] = 1'b0;
    v = '{1'b0, 32'h0000_0040, 32'h0, 4'h0, 32'hA5A5_5A5A, 1'b0};
    drive(1, v, 1'b0);
    @(posedge clk);
    q.push_back('{v.rdata, v.err});
    release_req(1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      chk("w3_req_ready_low", 32'(req_ready[1]), 32'd0);
    end while (!rsp_valid[1] && n < 40);
    chk("w3_latency", 32'(n), 32'd4);
    g = q.pop_front();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("w3_hold_valid%0d", k), 32'(rsp_valid[1]), 32'd1);
      chk($sformatf("w3_hold_rdata%0d", k), rsp_rdata[1], g.rdata);
      chk($sformatf("w3_hold_err%0d", k), 32'(rsp_err[1]), 32'(g.err));
      chk($sformatf("w3_hold_req_ready%0d", k), 32'(req_ready[1]), 32'd0);
    end
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    chk("w3_back_idle_valid", 32'(rsp_valid[1]), 32'd0);
    chk("w3_back_idle_ready", 32'(req_ready[1]), 32'd1);

    // Reset mid-transaction: instance 1 in WAIT after a write, instance 0
    // stalled in RESP on a read.
    rsp_ready[0] = 1'b0;
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h10; req_be[0] = 4'h0;
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h8;
    req_wdata[1] = 32'h0000_0055; req_be[1] = 4'hF;
    @(posedge clk);
    release_req(0);
    release_req(1);
    @(negedge clk);
    chk("rstmid_pre_valid0", 32'(rsp_valid[0]), 32'd1);
    chk("rstmid_pre_wait3", 32'(rsp_valid[1]), 32'd0);
    #2 rstn = 1'b0;
    #1;
    chk("rstmid_valid0", 32'(rsp_valid[0]), 32'd0);
    chk("rstmid_rdata0", rsp_rdata[0], 32'd0);
    chk("rstmid_valid3", 32'(rsp_valid[1]), 32'd0);
    chk("rstmid_ready3", 32'(req_ready[1]), 32'd1);
    rsp_ready[0] = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("rstmid_dropped%0d", k), 32'(rsp_valid[1]), 32'd0);
    end
    chk("rstmid_after_ready3", 32'(req_ready[1]), 32'd1);
    v = '{1'b0, 32'h0000_0008, 32'h0, 4'h0, 32'h0000_0055, 1'b0};
    txn(1, v, 4, 1'b0, "rstmid_rd");

`ifdef DATA_RAM_HS_PARITY_EN
    v = '{1'b1, 32'h0000_0004, 32'h0, 4'hF, 32'h0, 1'b0};
    txn(0, v, 1, 1'b1, "par_wr_inj");
    v = '{1'b0, 32'h0000_0004, 32'h0, 4'h0, 32'h0, 1'b1};
    txn(0, v, 1, 1'b0, "par_rd_bad");
    v = '{1'b1, 32'h0000_0004, 32'h0, 4'hF, 32'h0, 1'b0};
    txn(0, v, 1, 1'b0, "par_wr_ok");
    v = '{1'b0, 32'h0000_0004, 32'h0, 4'h0, 32'h0, 1'b0};
    txn(0, v, 1, 1'b0, "par_rd_ok");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/data_ram_hs.md
Name: data_ram_hs

Overview:
- Parametrised single-port data memory for the core's load/store path.
- Successor to the flat combinational-read RAM, which had only a write enable.
- Adds a valid/ready request and response handshake, per-byte write strobes, registered read data, programmable wait states, and error reporting for misaligned or out-of-range addresses.
- Sits between the LSU and the data memory array; one outstanding transaction at a time.

Parameters:
- DATA_W, 32: data word width in bits; must be a multiple of 8 (BE_W = DATA_W/8).
- DEPTH, 1024: number of words; any value from 2 up, need not be a power of 2.
- ADDR_W, 32: byte address width.
- WAIT_CYCLES, 0: extra cycles between acceptance and response; 0..15.

Ports:
- clk, in, 1: clock, rising edge.
- rstn, in, 1: asynchronous active-low reset.
- req_valid, in, 1: request present.
- req_ready, out, 1: block can accept a request.
- req_we, in, 1: 1 = write, 0 = read.
- req_addr, in, ADDR_W: byte address.
- req_wdata, in, DATA_W: write data.
- req_be, in, BE_W: byte write strobes; ignored on reads.
- rsp_valid, out, 1: response present.
- rsp_ready, in, 1: consumer accepts the response.
- rsp_rdata, out, DATA_W: read data; 0 for writes and errors.
- rsp_err, out, 1: access error.

Behaviour:
- Reset (async assert, sync deassert by the system): FSM goes to IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0, req_ready=1 once out of reset. Memory contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1.
    - Acceptance = req_valid && req_ready at a rising edge.
    - On acceptance: go to WAIT if WAIT_CYCLES>0 (counter loads WAIT_CYCLES-1), otherwise go to RESP.
  - WAIT: req_ready=0. Counter decrements each cycle; at 0, go to RESP.
  - RESP: rsp_valid=1, outputs held stable. On rsp_valid && rsp_ready go to IDLE. There is no same-cycle re-acceptance, so peak throughput is one transaction per 2+WAIT_CYCLES cycles.
- Word index = req_addr[ADDR_W-1:log2(BE_W)].
- Error conditions: req_addr[log2(BE_W)-1:0] != 0 (misaligned), or word index >= DEPTH.
- Normal operation, all at the acceptance edge:
  - Writes update each byte lane whose req_be bit is 1; req_be = 0 is a legal no-op with rsp_err=0.
  - Reads capture mem[index] into the response register.
- On error: no memory update, rsp_rdata=0, rsp_err=1.
- Response latency from the acceptance edge is WAIT_CYCLES+1 cycles until rsp_valid is high.
- A read following a write to the same word returns the written data.
- rsp_valid held while rsp_ready is low: the block stays in RESP indefinitely with data and err stable.
- Reset mid-transaction: the FSM aborts to IDLE and the response is dropped. A write already accepted stays committed.
- Inputs are sampled only at acceptance; changes to them after acceptance have no effect.

Optional Feature:
- Macro: DATA_RAM_HS_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte and written with its lane.
  - Extra input port par_inject (1 bit): when high at a write acceptance, the stored parity of the written lanes is inverted.
  - On a read, any parity mismatch across the word sets rsp_err=1. Data is still returned unmodified.
- Not defined: no parity storage and no par_inject port; rsp_err reflects address errors only.

Decomposition:
- Shared package data_ram_pkg:
  - FSM state typedef (IDLE=0, WAIT=1, RESP=2).
  - BE_W and OFS_W = log2(BE_W) derivation functions.
  - Maximum WAIT_CYCLES constant (15).
- One sub-module, data_ram_array: plain storage with a byte-lane write-enable vector and a registered read port (plus parity bits when the macro is defined).
- The top level contains the FSM, the address checks, and the response register.

Test Plan:
1. Reset, then write 0xDEADBEEF to 0x10 with be=0xF, then read 0x10 (WAIT_CYCLES=0) -> rsp_valid exactly 1 cycle after each acceptance; read returns 0xDEADBEEF, err=0.
2. Write 0x11223344 to 0x20 with be=0xF, then write 0xAABBCCDD with be=0b0101, then read 0x20 -> returns 0x11BB33DD.
3. Read 0x22 (misaligned), then write to 0x1000 (index 1024 = DEPTH) -> both give err=1 and rdata=0; a following read of 0xFFC returns its previous contents unchanged.
4. WAIT_CYCLES=3: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid rises 4 cycles after acceptance; rdata and err stay stable; req_ready=0 throughout; return to IDLE the cycle after rsp_ready=1.
5. Assert rstn=0 while in WAIT after a write of 0x55 to 0x8 -> rsp_valid=0 immediately; after release req_ready=1, and a read of 0x8 returns 0x55.
6. With DATA_RAM_HS_PARITY_EN: write 0x0 to 0x4 with par_inject=1, then read 0x4 -> rdata=0x0, err=1. Rewrite without inject, then read -> err=0.
